// File: rtl/radix4_seq_mult.sv
// radix4_seq_mult: sequential radix-4 multiplier, WIDTH/2 iterations; define SIGNED_MODE_EN to add iSigned for two's-complement operands.
module radix4_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iData_A,
  input  logic [WIDTH-1:0]   iData_B,
`ifdef SIGNED_MODE_EN
  input  logic               iSigned,
`endif
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult
);
  localparam int CW = $clog2(WIDTH/2) > 0 ? $clog2(WIDTH/2) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH/2 - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] mcand, acc, term, sum, a_ext;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0] cnt;
  logic in_sgn, sgn, accept, last, neg_top;
`ifdef SIGNED_MODE_EN
  assign in_sgn = iSigned;
`else
  assign in_sgn = 1'b0;
`endif
  assign accept = iStart && state != CALC;
  assign last = cnt == LAST;
  // in signed mode the top digit of B carries weight -2 on its upper bit
  assign neg_top = sgn && last;
  assign a_ext = {{WIDTH{in_sgn & iData_A[WIDTH-1]}}, iData_A};
  always_comb begin
    term = mplier[1:0] == 2'd0 ? '0 :
           mplier[1:0] == 2'd1 ? mcand :
           mplier[1:0] == 2'd2 ? (neg_top ? -(mcand << 1) : mcand << 1) :
                                 (neg_top ? -mcand : mcand + (mcand << 1));
    sum = acc + term;
  end
  always_ff @(posedge Clock)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? CALC : state == CALC ? (last ? DONE : CALC) : IDLE;
  always_comb begin
    oBusy = state == CALC;
    oDone = state == DONE;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc <= '0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      sgn <= 1'b0;
      oResult <= '0;
    end else if (accept) begin
      acc <= '0;
      cnt <= '0;
      mcand <= a_ext;
      mplier <= iData_B;
      sgn <= in_sgn;
    end else if (state == CALC) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      mcand <= mcand << 2;
      mplier <= mplier >> 2;
      if (last) oResult <= sum;
    end
  end
endmodule

// File: tb/tb_radix4_seq_mult.sv
// tb_radix4_seq_mult: scoreboard bench for radix4_seq_mult (WIDTH=16), signed cases under SIGNED_MODE_EN.
module tb_radix4_seq_mult;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [15:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] result;
  logic sgn_in = 0;
  int cyc = 0, run = 0, checks = 0, passes = 0;
  typedef struct {logic [31:0] res; int cyc;} exp_t;
  exp_t q[$];
  radix4_seq_mult #(.WIDTH(16)) dut (
    .Clock(clk),
    .Reset(rst),
    .iStart(start),
    .iData_A(a),
    .iData_B(b),
`ifdef SIGNED_MODE_EN
    .iSigned(sgn_in),
`endif
    .oBusy(busy),
    .oDone(done),
    .oResult(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] model(logic [15:0] x, logic [15:0] y, logic s);
    logic signed [31:0] sx, sy;
    sx = s ? 32'(signed'(x)) : {16'b0, x};
    sy = s ? 32'(signed'(y)) : {16'b0, y};
    return 32'(sx * sy);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst) run = 0;
    else begin
      if (busy) run++;
      if (done) begin
        if (q.size() == 0) check("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          check("result", result, e.res);
          check("latency", cyc, e.cyc);
          check("busy_len", run, 8);
        end
        run = 0;
      end
    end
  end
  task automatic push(logic [15:0] x, logic [15:0] y, logic s, int at);
    exp_t e;
`ifdef SIGNED_MODE_EN
    e.res = model(x, y, s);
`else
    e.res = model(x, y, 1'b0);
`endif
    e.cyc = at;
    q.push_back(e);
  endtask
  task automatic go(logic [15:0] x, logic [15:0] y, logic s);
    @(negedge clk);
    a = x;
    b = y;
    sgn_in = s;
    start = 1;
    push(x, y, s, cyc + 9);
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("timeout", q.size(), 0);
      q.delete();
    end
  endtask
  initial begin
    int c;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst = 0;
    go(16'd3, 16'd5, 0);
    check("busy_after_start", busy, 1);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold", result, 32'h0000000F);
    go(16'hFFFF, 16'hFFFF, 0);
    wait_done();
    go(16'h1234, 16'h0000, 0);
    wait_done();
    go(16'd100, 16'd200, 0);
    repeat (2) @(negedge clk);
    a = 16'd7;
    b = 16'd9;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    repeat (3) @(negedge clk);
    @(negedge clk);
    c = cyc;
    a = 16'd2;
    b = 16'd7;
    start = 1;
    push(16'd2, 16'd7, 0, c + 9);
    push(16'd10, 16'd10, 0, c + 18);
    @(negedge clk);
    a = 16'd10;
    b = 16'd10;
    repeat (9) @(negedge clk);
    start = 0;
    check("b2b_no_idle", busy, 1);
    wait_done();
    go(16'hABCD, 16'h1357, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    q.delete();
    @(negedge clk);
    rst = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      go(16'($urandom), 16'($urandom), 0);
      wait_done();
    end
`ifdef SIGNED_MODE_EN
    go(16'hFFFF, 16'hFFFF, 1);
    wait_done();
    check("signed_m1", result, 32'h00000001);
    go(16'hFFFE, 16'h0003, 1);
    wait_done();
    check("signed_m2x3", result, 32'hFFFFFFFA);
    go(16'hFFFE, 16'h0003, 0);
    wait_done();
    go(16'h8000, 16'h8000, 1);
    wait_done();
    for (int i = 0; i < 8; i++) begin
      go(16'($urandom), 16'($urandom), 1);
      wait_done();
    end
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/radix4_seq_mult.md
RADIX4_SEQ_MULT -- requirements
Module: radix4_seq_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; legal values are even integers from 4 to 32.
REQ-002 The block SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port iStart, input, 1 bit, a request to start a multiplication.
REQ-005 The block SHALL have port iData_A, input, WIDTH bits, the multiplicand.
REQ-006 The block SHALL have port iData_B, input, WIDTH bits, the multiplier.
REQ-007 The block SHALL have port oBusy, output, 1 bit, high while iterating.
REQ-008 The block SHALL have port oDone, output, 1 bit, a one-cycle completion pulse.
REQ-009 The block SHALL have port oResult, output, 2*WIDTH bits, the registered product.

Function
REQ-010 The block SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-011 iStart SHALL be accepted only in IDLE or DONE; it SHALL be ignored in CALC.
REQ-012 On acceptance, the block SHALL capture iData_A and iData_B, clear the accumulator and iteration counter, and enter CALC.
REQ-013 In CALC, each cycle SHALL consume the two LSBs of the captured multiplier as a radix-4 digit d in {0,1,2,3}.
REQ-014 In each CALC cycle, the accumulator SHALL add d*A shifted left by 2*k, where k is the iteration count; 3A is formed as A + 2A; the add is at least 2*WIDTH bits wide with no truncation.
REQ-015 CALC SHALL last exactly WIDTH/2 cycles, after which the state SHALL be DONE.
REQ-016 oDone SHALL be high for exactly the single DONE cycle, WIDTH/2 cycles after the accepting edge (8 cycles for WIDTH=16).
REQ-017 oResult SHALL be updated only on entry to DONE and SHALL hold its value until the next DONE entry or reset.
REQ-018 DONE SHALL return to IDLE unless iStart is high, in which case it goes to CALC; this permits back-to-back operations with no idle cycle.
REQ-019 oBusy SHALL be high exactly when the state is CALC.
REQ-020 Input changes during CALC SHALL NOT affect the product in progress.
REQ-021 Unsigned operation SHALL return the exact 2*WIDTH-bit product; overflow is impossible.

Reset
REQ-022 When Reset is high at a rising edge, the state SHALL become IDLE and oBusy, oDone, oResult, the accumulator and the counter SHALL all become 0.
REQ-023 Reset SHALL take priority over iStart.
REQ-024 Reset during CALC SHALL abort the operation with no oDone pulse.

Configuration
REQ-025 With macro SIGNED_MODE_EN defined, the block SHALL have an extra input iSigned, 1 bit, captured together with the operands.
REQ-026 With SIGNED_MODE_EN defined and iSigned=1, oResult SHALL be the two's-complement product of two's-complement operands.
REQ-027 With SIGNED_MODE_EN defined, the latency SHALL be identical to unsigned mode.
REQ-028 Without SIGNED_MODE_EN, port iSigned SHALL be absent and the block SHALL be unsigned only.

Verification
REQ-029 Scenario (WIDTH=16): A=3, B=5, iStart for 1 cycle -> oBusy high 8 cycles, then oDone for 1 cycle with oResult=0x0000000F.
REQ-030 Scenario: A=0xFFFF, B=0xFFFF -> oResult=0xFFFE0001; also A=0x1234, B=0 -> oResult=0.
REQ-031 Scenario: iStart pulsed mid-CALC with new operands -> ignored; the original product completes on schedule.
REQ-032 Scenario: iStart held high with A=2, B=7 then A=10, B=10 -> oDone pulses 9 cycles apart; results 14, then 100; no IDLE cycle between.
REQ-033 Scenario: Reset asserted in the 4th CALC cycle -> next cycle is IDLE, all outputs 0, no oDone.
REQ-034 Scenario (SIGNED_MODE_EN, iSigned=1): A=0xFFFF, B=0xFFFF -> 0x00000001; A=0xFFFE, B=3 -> 0xFFFFFFFA; with iSigned=0, the same operands give the unsigned products.
